// File: rtl/tcp_pkg.sv
// +----------------------------------------------------------------------------+
// | tcp_pkg: shared widths, TCP header, flow-state and scheduler types.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package tcp_pkg;

  localparam int FLOWID_W         = 4;
  localparam int RX_PAYLOAD_PTR_W = 12;
  localparam int PAYLOAD_LEN_W    = 16;
  localparam int TCP_FLAG_ACK_BIT = 4;

  typedef struct packed {
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [15:0] window;
    logic [7:0]  flags;
  } tcp_pkt_hdr;

  typedef struct packed {
    logic [31:0] ack_num;
    logic [15:0] their_win_size;
  } ack_state_struct;

  typedef struct packed {
    ack_state_struct our_ack_state;
    logic [31:0]     their_ack_num;
    logic [15:0]     our_win_size;
  } smol_rx_state_struct;

  typedef struct packed {
    logic [31:0] our_seq_num;
  } smol_tx_state_struct;

  typedef struct packed {
    logic [RX_PAYLOAD_PTR_W-1:0] addr;
    logic [PAYLOAD_LEN_W-1:0]    len;
  } payload_buf_struct;

  typedef enum logic [1:0] {
    SCHED_NOP   = 2'd0,
    SCHED_SET   = 2'd1,
    SCHED_CLEAR = 2'd2
  } sched_flag_e;

  typedef struct packed {
    logic [FLOWID_W-1:0] flowid;
    sched_flag_e         ack_pend;
    sched_flag_e         rt_pend;
    sched_flag_e         data_pend;
    logic [31:0]         rt_timestamp;
    logic [31:0]         ack_timestamp;
  } sched_cmd_struct;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    CALC  = 2'd2,
    ISSUE = 2'd3
  } rx_eng_state_e;

endpackage

`default_nettype wire

// File: rtl/tcp_rx_accept_calc.sv
// +----------------------------------------------------------------------------+
// | tcp_rx_accept_calc: combinational ACK-window and in-order data acceptance. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tcp_rx_accept_calc
  import tcp_pkg::*;
(
  input  tcp_pkt_hdr                  hdr,
  input  logic [PAYLOAD_LEN_W-1:0]    payload_len,
  input  smol_rx_state_struct         rx_state,
  input  smol_tx_state_struct         tx_state,
  input  logic [RX_PAYLOAD_PTR_W:0]   head_ptr,
  output smol_rx_state_struct         new_rx_state,
  output payload_buf_struct           desc,
  output logic                        accept,
  output logic                        rt_clear,
  output logic                        win_opened
);

  localparam logic [RX_PAYLOAD_PTR_W:0] c_BUF_BYTES = {1'b1, {RX_PAYLOAD_PTR_W{1'b0}}};

  logic [31:0]               w_d;
  logic [31:0]               w_outstanding;
  logic                      w_ack_flag;
  logic                      w_ack_adv;
  logic [RX_PAYLOAD_PTR_W:0] w_used;
  logic [RX_PAYLOAD_PTR_W:0] w_free;
  logic [31:0]               w_win_raw;
  logic                      w_unused_flags;

  assign w_unused_flags = ^{hdr.flags[7:TCP_FLAG_ACK_BIT+1], hdr.flags[TCP_FLAG_ACK_BIT-1:0]};

  always_comb begin
    new_rx_state  = rx_state;
    w_ack_flag    = hdr.flags[TCP_FLAG_ACK_BIT];
    w_d           = hdr.ack_num - rx_state.our_ack_state.ack_num;
    w_outstanding = tx_state.our_seq_num - rx_state.our_ack_state.ack_num;
    w_ack_adv     = w_ack_flag && (w_d != 32'd0) && (w_d <= w_outstanding);

    if (w_ack_adv) begin
      new_rx_state.our_ack_state.ack_num        = hdr.ack_num;
      new_rx_state.our_ack_state.their_win_size = hdr.window;
    end else if (w_ack_flag && (w_d == 32'd0)) begin
      new_rx_state.our_ack_state.their_win_size = hdr.window;
    end

    // Pointers carry one wrap bit, so the subtraction is exact across buffer wrap.
    w_used = rx_state.their_ack_num[RX_PAYLOAD_PTR_W:0] - head_ptr;
    w_free = c_BUF_BYTES - w_used;
    accept = (payload_len != '0) && (hdr.seq_num == rx_state.their_ack_num) &&
             (32'(payload_len) <= 32'(w_free));

    if (accept) begin
      new_rx_state.their_ack_num = rx_state.their_ack_num + 32'(payload_len);
    end

    w_win_raw = 32'(w_free) - (accept ? 32'(payload_len) : 32'd0);
    new_rx_state.our_win_size = (w_win_raw > 32'h0000_FFFF) ? 16'hFFFF : w_win_raw[15:0];

    desc.addr  = hdr.seq_num[RX_PAYLOAD_PTR_W-1:0];
    desc.len   = payload_len;
    rt_clear   = w_ack_adv && (hdr.ack_num == tx_state.our_seq_num);
    win_opened = (rx_state.our_ack_state.their_win_size == 16'd0) &&
                 (new_rx_state.our_ack_state.their_win_size != 16'd0);
  end

endmodule

`default_nettype wire

// File: rtl/tcp_rx_proto_engine.sv
// +----------------------------------------------------------------------------+
// | tcp_rx_proto_engine: per-segment RX control FSM; reads flow state, writes  |
// | back RX state, issues payload-store and scheduler commands. Rev 1.0        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tcp_rx_proto_engine
  import tcp_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pkt_val,
  output logic                        pkt_rdy,
  input  logic [FLOWID_W-1:0]         pkt_flowid,
  input  tcp_pkt_hdr                  pkt_hdr,
  input  logic [PAYLOAD_LEN_W-1:0]    pkt_payload_len,
  output logic                        state_rd_req_val,
  output logic [FLOWID_W-1:0]         state_rd_req_addr,
  input  smol_rx_state_struct         rx_state_rd_resp_data,
  input  smol_tx_state_struct         tx_state_rd_resp_data,
  input  logic [RX_PAYLOAD_PTR_W:0]   rx_head_ptr_rd_resp_data,
  output logic                        rx_state_wr_req_val,
  output logic [FLOWID_W-1:0]         rx_state_wr_req_addr,
  output smol_rx_state_struct         rx_state_wr_req_data,
  output logic                        payload_cmd_val,
  input  logic                        payload_cmd_rdy,
  output logic [FLOWID_W-1:0]         payload_cmd_flowid,
  output payload_buf_struct           payload_cmd_desc,
  output logic                        payload_cmd_accept,
  output logic                        sched_cmd_val,
  input  logic                        sched_cmd_rdy,
  output sched_cmd_struct             sched_cmd_data
);

  rx_eng_state_e             r_state;
  logic [FLOWID_W-1:0]       r_flowid;
  tcp_pkt_hdr                r_hdr;
  logic [PAYLOAD_LEN_W-1:0]  r_len;

  smol_rx_state_struct       w_new_rx;
  payload_buf_struct         w_desc;
  logic                      w_accept;
  logic                      w_rt_clear;
  logic                      w_win_opened;
  logic                      w_pay_done;
  logic                      w_sched_done;

  tcp_rx_accept_calc u_calc (
    .hdr          (r_hdr),
    .payload_len  (r_len),
    .rx_state     (rx_state_rd_resp_data),
    .tx_state     (tx_state_rd_resp_data),
    .head_ptr     (rx_head_ptr_rd_resp_data),
    .new_rx_state (w_new_rx),
    .desc         (w_desc),
    .accept       (w_accept),
    .rt_clear     (w_rt_clear),
    .win_opened   (w_win_opened)
  );

  assign w_pay_done   = !payload_cmd_val || payload_cmd_rdy;
  assign w_sched_done = !sched_cmd_val   || sched_cmd_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state              <= IDLE;
      r_flowid             <= '0;
      r_hdr                <= '0;
      r_len                <= '0;
      pkt_rdy              <= 1'b1;
      state_rd_req_val     <= 1'b0;
      state_rd_req_addr    <= '0;
      rx_state_wr_req_val  <= 1'b0;
      rx_state_wr_req_addr <= '0;
      rx_state_wr_req_data <= '0;
      payload_cmd_val      <= 1'b0;
      payload_cmd_flowid   <= '0;
      payload_cmd_desc     <= '0;
      payload_cmd_accept   <= 1'b0;
      sched_cmd_val        <= 1'b0;
      sched_cmd_data       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (pkt_val && pkt_rdy) begin
            r_flowid          <= pkt_flowid;
            r_hdr             <= pkt_hdr;
            r_len             <= pkt_payload_len;
            pkt_rdy           <= 1'b0;
            state_rd_req_val  <= 1'b1;
            state_rd_req_addr <= pkt_flowid;
            r_state           <= RD;
          end
        end
        RD: begin
          state_rd_req_val <= 1'b0;
          r_state          <= CALC;
        end
        CALC: begin
          rx_state_wr_req_val      <= 1'b1;
          rx_state_wr_req_addr     <= r_flowid;
          rx_state_wr_req_data     <= w_new_rx;
          payload_cmd_val          <= (r_len != '0);
          payload_cmd_flowid       <= r_flowid;
          payload_cmd_desc         <= w_desc;
          payload_cmd_accept       <= w_accept;
          sched_cmd_val            <= 1'b1;
          sched_cmd_data.flowid    <= r_flowid;
          // Every data-bearing segment triggers an ACK, including dropped ones.
          sched_cmd_data.ack_pend  <= (r_len != '0) ? SCHED_SET : SCHED_NOP;
          sched_cmd_data.rt_pend   <= w_rt_clear ? SCHED_CLEAR : SCHED_NOP;
          sched_cmd_data.data_pend <= w_win_opened ? SCHED_SET : SCHED_NOP;
          sched_cmd_data.rt_timestamp  <= '0;
          sched_cmd_data.ack_timestamp <= '0;
          r_state                  <= ISSUE;
        end
        ISSUE: begin
          rx_state_wr_req_val <= 1'b0;
          if (payload_cmd_val && payload_cmd_rdy) payload_cmd_val <= 1'b0;
          if (sched_cmd_val && sched_cmd_rdy)     sched_cmd_val   <= 1'b0;
          if (w_pay_done && w_sched_done) begin
            pkt_rdy <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          pkt_rdy <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tcp_rx_proto_engine.sv
// +----------------------------------------------------------------------------+
// | tb_tcp_rx_proto_engine: directed + random segments against a flow model.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_tcp_rx_proto_engine;
  import tcp_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      pkt_val = 1'b0;
  logic                      pkt_rdy;
  logic [FLOWID_W-1:0]       pkt_flowid = '0;
  tcp_pkt_hdr                pkt_hdr = '0;
  logic [PAYLOAD_LEN_W-1:0]  pkt_payload_len = '0;
  logic                      state_rd_req_val;
  logic [FLOWID_W-1:0]       state_rd_req_addr;
  smol_rx_state_struct       rx_resp = '0;
  smol_tx_state_struct       tx_resp = '0;
  logic [RX_PAYLOAD_PTR_W:0] head_resp = '0;
  logic                      rx_state_wr_req_val;
  logic [FLOWID_W-1:0]       rx_state_wr_req_addr;
  smol_rx_state_struct       rx_state_wr_req_data;
  logic                      payload_cmd_val;
  logic                      payload_cmd_rdy = 1'b0;
  logic [FLOWID_W-1:0]       payload_cmd_flowid;
  payload_buf_struct         payload_cmd_desc;
  logic                      payload_cmd_accept;
  logic                      sched_cmd_val;
  logic                      sched_cmd_rdy = 1'b0;
  sched_cmd_struct           sched_cmd_data;

  int checks = 0;
  int errors = 0;

  // Reference flow memories; the engine reads these and the model owns updates.
  smol_rx_state_struct       m_rx   [16];
  smol_tx_state_struct       m_tx   [16];
  logic [RX_PAYLOAD_PTR_W:0] m_head [16];

  int                  wr_cnt = 0;
  logic [FLOWID_W-1:0] wr_addr_q = '0;
  smol_rx_state_struct wr_data_q = '0;
  payload_buf_struct   cap_desc;
  logic                cap_accept;
  sched_cmd_struct     cap_sched;

  tcp_rx_proto_engine dut (
    .clk                      (clk),
    .rst                      (rst),
    .pkt_val                  (pkt_val),
    .pkt_rdy                  (pkt_rdy),
    .pkt_flowid               (pkt_flowid),
    .pkt_hdr                  (pkt_hdr),
    .pkt_payload_len          (pkt_payload_len),
    .state_rd_req_val         (state_rd_req_val),
    .state_rd_req_addr        (state_rd_req_addr),
    .rx_state_rd_resp_data    (rx_resp),
    .tx_state_rd_resp_data    (tx_resp),
    .rx_head_ptr_rd_resp_data (head_resp),
    .rx_state_wr_req_val      (rx_state_wr_req_val),
    .rx_state_wr_req_addr     (rx_state_wr_req_addr),
    .rx_state_wr_req_data     (rx_state_wr_req_data),
    .payload_cmd_val          (payload_cmd_val),
    .payload_cmd_rdy          (payload_cmd_rdy),
    .payload_cmd_flowid       (payload_cmd_flowid),
    .payload_cmd_desc         (payload_cmd_desc),
    .payload_cmd_accept       (payload_cmd_accept),
    .sched_cmd_val            (sched_cmd_val),
    .sched_cmd_rdy            (sched_cmd_rdy),
    .sched_cmd_data           (sched_cmd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (state_rd_req_val) begin
      rx_resp   <= m_rx[state_rd_req_addr];
      tx_resp   <= m_tx[state_rd_req_addr];
      head_resp <= m_head[state_rd_req_addr];
    end
    if (rx_state_wr_req_val) begin
      wr_cnt    <= wr_cnt + 1;
      wr_addr_q <= rx_state_wr_req_addr;
      wr_data_q <= rx_state_wr_req_data;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_flow(input int f, input logic [31:0] their_ack, input logic [12:0] head,
                          input logic [31:0] ack, input logic [15:0] win, input logic [31:0] tseq);
    m_rx[f] = '0;
    m_rx[f].their_ack_num = their_ack;
    m_rx[f].our_ack_state.ack_num = ack;
    m_rx[f].our_ack_state.their_win_size = win;
    m_tx[f].our_seq_num = tseq;
    m_head[f] = head;
  endtask

  task automatic run_seg(input int f, input tcp_pkt_hdr h, input int len, input int pdly, input int sdly);
    smol_rx_state_struct old_rx, exp_rx;
    sched_cmd_struct     exp_s, s_first;
    payload_buf_struct   exp_desc;
    logic [31:0] d, outst;
    logic [12:0] used;
    int free, ow, start;
    logic ackf, adv, acc, got_p, got_s, s_seen;

    // Model: evaluate the segment against the flow's state with plain arithmetic.
    old_rx = m_rx[f];
    exp_rx = old_rx;
    ackf  = h.flags[TCP_FLAG_ACK_BIT];
    d     = h.ack_num - old_rx.our_ack_state.ack_num;
    outst = m_tx[f].our_seq_num - old_rx.our_ack_state.ack_num;
    adv   = ackf && d != 0 && d <= outst;
    if (ackf && d <= outst) exp_rx.our_ack_state.their_win_size = h.window;
    if (adv) exp_rx.our_ack_state.ack_num = h.ack_num;
    used = old_rx.their_ack_num[12:0] - m_head[f];
    free = 4096 - int'(used);
    acc  = len != 0 && h.seq_num == old_rx.their_ack_num && len <= free;
    if (acc) exp_rx.their_ack_num = old_rx.their_ack_num + len;
    ow = free - (acc ? len : 0);
    if (ow > 65535) ow = 65535;
    exp_rx.our_win_size = ow[15:0];
    exp_desc.addr = h.seq_num[11:0];
    exp_desc.len  = len[15:0];
    exp_s = '0;
    exp_s.flowid    = f[FLOWID_W-1:0];
    exp_s.ack_pend  = (len != 0) ? SCHED_SET : SCHED_NOP;
    exp_s.rt_pend   = (adv && h.ack_num == m_tx[f].our_seq_num) ? SCHED_CLEAR : SCHED_NOP;
    exp_s.data_pend = (old_rx.our_ack_state.their_win_size == 0 &&
                       exp_rx.our_ack_state.their_win_size != 0) ? SCHED_SET : SCHED_NOP;

    for (int t = 0; t < 20 && !pkt_rdy; t++) @(negedge clk);
    check("idle_pkt_rdy", pkt_rdy, 1'b1);
    start = wr_cnt;
    pkt_val = 1'b1; pkt_flowid = f[FLOWID_W-1:0]; pkt_hdr = h; pkt_payload_len = len[15:0];
    @(negedge clk);
    pkt_val = 1'b0;

    got_p = (len == 0); got_s = 1'b0; s_seen = 1'b0; s_first = '0;
    for (int c = 0; c < 60 && !(got_p && got_s); c++) begin
      payload_cmd_rdy = (c >= 2 + pdly);
      sched_cmd_rdy   = (c >= 2 + sdly);
      #1;
      check("busy_pkt_rdy", pkt_rdy, 1'b0);
      if (len == 0) check("pure_ack_no_payload", payload_cmd_val, 1'b0);
      if (s_seen && !got_s) begin
        check("sched_val_hold", sched_cmd_val, 1'b1);
        check("sched_data_hold", sched_cmd_data, s_first);
      end
      if (sched_cmd_val && !s_seen) begin s_seen = 1'b1; s_first = sched_cmd_data; end
      if (payload_cmd_val && payload_cmd_rdy && !got_p) begin
        got_p = 1'b1;
        cap_desc = payload_cmd_desc; cap_accept = payload_cmd_accept;
        check("payload_desc", payload_cmd_desc, exp_desc);
        check("payload_accept", payload_cmd_accept, acc);
        check("payload_flowid", payload_cmd_flowid, f[FLOWID_W-1:0]);
      end
      if (sched_cmd_val && sched_cmd_rdy && !got_s) begin
        got_s = 1'b1;
        cap_sched = sched_cmd_data;
        check("sched_data", sched_cmd_data, exp_s);
      end
      @(negedge clk);
    end
    check("handshake_timeout", {got_p, got_s}, 2'b11);
    #1;
    check("done_pkt_rdy", pkt_rdy, 1'b1);
    check("done_vals_low", {payload_cmd_val, sched_cmd_val, rx_state_wr_req_val}, 3'b000);
    check("write_count", wr_cnt - start, 1);
    check("write_addr", wr_addr_q, f[FLOWID_W-1:0]);
    check("write_data", wr_data_q, exp_rx);
    payload_cmd_rdy = 1'b0;
    sched_cmd_rdy   = 1'b0;
    m_rx[f] = exp_rx;
  endtask

  function automatic tcp_pkt_hdr mk_hdr(input logic [31:0] seq, input logic [31:0] ack,
                                        input logic [15:0] win, input logic ackf);
    tcp_pkt_hdr h;
    h = '0;
    h.seq_num = seq; h.ack_num = ack; h.window = win;
    h.flags[TCP_FLAG_ACK_BIT] = ackf;
    return h;
  endfunction

  initial begin
    int start;
    for (int i = 0; i < 16; i++) set_flow(i, $urandom, '0, $urandom, 16'd0, '0);
    for (int i = 0; i < 16; i++) begin
      m_tx[i].our_seq_num = m_rx[i].our_ack_state.ack_num + $urandom_range(0, 3000);
      m_head[i] = m_rx[i].their_ack_num[12:0] - 13'($urandom_range(0, 4096));
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("reset_pkt_rdy", pkt_rdy, 1'b1);
    check("reset_vals", {state_rd_req_val, rx_state_wr_req_val, payload_cmd_val, sched_cmd_val}, 4'b0);
    check("reset_sched_data", sched_cmd_data, '0);

    // In-order data
    set_flow(1, 32'd1000, 13'd1000, 32'd0, 16'd0, 32'd0);
    run_seg(1, mk_hdr(32'd1000, 32'd0, 16'd0, 1'b0), 100, 0, 0);
    check("tp_inorder_accept", cap_accept, 1'b1);
    check("tp_inorder_addr", cap_desc.addr, 12'd1000);
    check("tp_inorder_ack", wr_data_q.their_ack_num, 32'd1100);
    check("tp_inorder_ackpend", cap_sched.ack_pend, SCHED_SET);

    // Out-of-order
    run_seg(1, mk_hdr(32'd1200, 32'd0, 16'd0, 1'b0), 50, 1, 0);
    check("tp_ooo_accept", cap_accept, 1'b0);
    check("tp_ooo_ack", wr_data_q.their_ack_num, 32'd1100);

    // ACK advance closing all outstanding data
    set_flow(2, 32'd0, 13'd0, 32'd500, 16'd0, 32'd700);
    run_seg(2, mk_hdr(32'd0, 32'd700, 16'h2000, 1'b1), 0, 0, 0);
    check("tp_ack_num", wr_data_q.our_ack_state.ack_num, 32'd700);
    check("tp_ack_win", wr_data_q.our_ack_state.their_win_size, 16'h2000);
    check("tp_ack_rtclear", cap_sched.rt_pend, SCHED_CLEAR);

    // Overflow: 4000 bytes in use, 200 more do not fit
    set_flow(3, 32'd5000, 13'd1000, 32'd0, 16'd0, 32'd0);
    run_seg(3, mk_hdr(32'd5000, 32'd0, 16'd0, 1'b0), 200, 0, 0);
    check("tp_overflow_drop", cap_accept, 1'b0);

    // Sequence wrap across 2^32
    set_flow(4, 32'hFFFF_FFF0, 13'h1FF0, 32'd0, 16'd0, 32'd0);
    run_seg(4, mk_hdr(32'hFFFF_FFF0, 32'd0, 16'd0, 1'b0), 32, 0, 0);
    check("tp_wrap_ack", wr_data_q.their_ack_num, 32'h0000_0010);

    // Scheduler backpressure for 5 cycles, payload immediate
    run_seg(4, mk_hdr(32'h0000_0010, 32'd0, 16'd0, 1'b0), 64, 0, 5);

    // Async reset while in CALC
    start = wr_cnt;
    pkt_val = 1'b1; pkt_flowid = 4'd5; pkt_hdr = mk_hdr(m_rx[5].their_ack_num, 32'd0, 16'd0, 1'b0);
    pkt_payload_len = 16'd10;
    @(negedge clk); pkt_val = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_calc_vals", {state_rd_req_val, rx_state_wr_req_val, payload_cmd_val, sched_cmd_val}, 4'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_calc_no_write", wr_cnt - start, 0);
    check("rst_calc_pkt_rdy", pkt_rdy, 1'b1);

    for (int n = 0; n < 40; n++) begin
      int f, len, r;
      logic [31:0] seq, ack, outst;
      f = $urandom_range(0, 15);
      m_tx[f].our_seq_num = m_tx[f].our_seq_num + $urandom_range(0, 2000);
      m_head[f] = m_rx[f].their_ack_num[12:0] - 13'($urandom_range(0, 4096));
      r = $urandom_range(0, 9);
      seq = (r < 6) ? m_rx[f].their_ack_num :
            (r < 8) ? m_rx[f].their_ack_num + $urandom_range(1, 3000) : $urandom;
      outst = m_tx[f].our_seq_num - m_rx[f].our_ack_state.ack_num;
      r = $urandom_range(0, 9);
      ack = (r < 4) ? m_rx[f].our_ack_state.ack_num + $urandom_range(0, outst) :
            (r < 6) ? m_rx[f].our_ack_state.ack_num :
            (r < 8) ? m_rx[f].our_ack_state.ack_num + outst + $urandom_range(1, 100) :
                      m_rx[f].our_ack_state.ack_num - $urandom_range(1, 100);
      len = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4200);
      run_seg(f, mk_hdr(seq, ack, ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom),
                        $urandom_range(0, 4) != 0), len, $urandom_range(0, 4), $urandom_range(0, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tcp_rx_proto_engine.md
Name: tcp_rx_proto_engine

Overview:
Receive-side protocol engine, the counterpart of the TX datapath. Takes one parsed TCP segment at a time and reads the per-flow RX state, TX sequence state and app RX head pointer. It decides in-order data acceptance and ACK advancement, writes back RX state, and issues a payload-store command and a scheduler update. The block contains its own control FSM plus datapath; it sits between the RX header parser and the flow-state memories, payload buffer copier and TX scheduler.

Parameters:
FLOWID_W, from tcp_pkg, flow index width
RX_PAYLOAD_PTR_W, from tcp_pkg, log2 of per-flow RX buffer bytes; pointers carry one extra wrap bit
PAYLOAD_LEN_W, 16, segment payload length width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
pkt_val  in  1  segment valid
pkt_rdy  out  1  engine idle, segment accepted on val&rdy
pkt_flowid  in  FLOWID_W  flow of segment
pkt_hdr  in  tcp_pkt_hdr  parsed TCP header
pkt_payload_len  in  PAYLOAD_LEN_W  payload bytes
state_rd_req_val  out  1  read strobe for all three memories
state_rd_req_addr  out  FLOWID_W  flowid
rx_state_rd_resp_data  in  smol_rx_state_struct  one-cycle read latency
tx_state_rd_resp_data  in  smol_tx_state_struct  supplies our_seq_num
rx_head_ptr_rd_resp_data  in  RX_PAYLOAD_PTR_W+1  app consume pointer
rx_state_wr_req_val  out  1  write strobe
rx_state_wr_req_addr  out  FLOWID_W  flowid
rx_state_wr_req_data  out  smol_rx_state_struct  updated state
payload_cmd_val  out  1  store command valid
payload_cmd_rdy  in  1
payload_cmd_flowid  out  FLOWID_W
payload_cmd_desc  out  payload_buf_struct  buffer addr/len
payload_cmd_accept  out  1  1 = copy into buffer, 0 = discard payload
sched_cmd_val  out  1
sched_cmd_rdy  in  1
sched_cmd_data  out  sched_cmd_struct  scheduler flag update

Behaviour:
- Reset (async): FSM to IDLE; pkt_rdy=1 after reset release; all val outputs=0; data registers cleared to 0. Reset mid-operation discards the segment with no state write.
- FSM: IDLE -> RD (state_rd_req_val=1 for one cycle) -> CALC (capture responses, compute) -> ISSUE -> IDLE.
  - IDLE: pkt_rdy=1; on handshake, register flowid/hdr/len.
  - RD: one cycle.
  - CALC: register all results.
  - ISSUE: rx_state_wr_req_val pulses exactly one cycle on ISSUE entry. payload_cmd_val (only if pkt_payload_len!=0) and sched_cmd_val each hold until their own handshake, completing in any order or the same cycle. Return to IDLE the cycle after the last outstanding handshake.
  - Minimum segment interval: 4 cycles. The next segment's read occurs after the previous write, so there is no same-flow hazard.
- ACK processing: all arithmetic is modulo 2^32.
  - d = hdr.ack_num - rx.our_ack_state.ack_num; outstanding = tx.our_seq_num - rx.our_ack_state.ack_num.
  - If the ACK flag is set and 0 < d <= outstanding: ack_num <- hdr.ack_num and their_win_size <- hdr.window.
  - If d==0: window only.
  - Otherwise (old or beyond seq): no change.
- Data acceptance:
  - used = their_ack_num[PTR:0] - head_ptr; free = 2^RX_PAYLOAD_PTR_W - used. Both use RX_PAYLOAD_PTR_W+1-bit wrap arithmetic.
  - Accept iff len!=0 and hdr.seq_num==their_ack_num and len<=free. On accept: their_ack_num += len; desc.addr = seq_num[RX_PAYLOAD_PTR_W-1:0]; desc.len = len; accept=1.
  - Out-of-order or overflow: their_ack_num unchanged, accept=0, desc.len=len.
- our_win_size: free minus accepted len, saturated to 16'hFFFF.
- sched_cmd_data:
  - flowid.
  - ack_pend = SET if len!=0, else NOP. Duplicate ACKs are generated for dropped data.
  - rt_pend = CLEAR if ACK advanced and new ack_num==our_seq_num, else NOP.
  - data_pend = SET if the window changed from 0 to nonzero, else NOP.
  - All timestamps 0.
- Pure ACK (len=0) never raises payload_cmd_val.

Decomposition:
- tcp_pkg holds existing smol_rx_state_struct, smol_tx_state_struct, sched_cmd_struct, and new rx_eng_state_e enum {IDLE,RD,CALC,ISSUE}.
- Sub-module tcp_rx_accept_calc: combinational ACK-window and data-acceptance math, unit-testable.

Test Plan:
- In-order data: their_ack_num=1000, head=1000, seq=1000, len=100 -> accept=1, addr=1000 mod buf, their_ack_num=1100, ack_pend SET, one write strobe.
- Out-of-order: seq=1200 with their_ack_num=1100, len=50 -> accept=0, their_ack_num stays 1100, ack_pend SET.
- ACK advance: ack_num=500, our_seq_num=700, hdr ACK 700 window 0x2000 -> ack_num=700, their_win_size=0x2000, rt_pend CLEAR, no payload_cmd.
- Wrap and overflow: buffer 4096, used=4000, len=200 -> drop. Seq near 0xFFFFFFF0 with len 32 wraps to 0x10 correctly.
- Backpressure: sched_cmd_rdy low 5 cycles, payload rdy immediate -> sched_cmd_val held stable, pkt_rdy=0 until both done, single write strobe.
- Async rst asserted in CALC -> all val=0 immediately, no write, pkt_rdy=1 after release.
